i2cmb_wb_sequencer: RTL
=======================

Name: i2cmb_wb_sequencer

Overview:
- Hardware Wishbone master that executes complete byte-level I2C transactions by programming the iicmb_m_wb core registers: CSR at address 0, DPR at 1, CMDR at 2.
- Sits directly upstream of the I2C multi-bus controller and drives its Wishbone slave port and irq.
- Replaces software command sequencing: accepts one transaction request, streams write data in, streams read data out, and reports completion status.

Parameters:
NUM_I2C_BUSSES, 1, number of controller busses; req_bus values >= this are rejected.
MAX_LEN, 64, maximum data bytes per transaction.
IRQ_TIMEOUT, 100000, clk_i cycles to wait for irq_i before aborting.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid  in  1  transaction request valid
req_ready  out  1  sequencer idle and able to accept a request
req_rw  in  1  0 = write, 1 = read
req_addr  in  7  I2C slave address
req_bus  in  4  bus id for the Set Bus command
req_len  in  7  data byte count, 0..MAX_LEN
wr_data  in  8  write byte
wr_valid  in  1  write byte valid
wr_ready  out  1  write byte accepted this cycle
rd_data  out  8  read byte
rd_valid  out  1  one-cycle pulse per read byte; no backpressure
done  out  1  one-cycle completion pulse
status  out  3  000 OK, 001 NAK, 010 ARB_LOST, 011 ERR, 100 TIMEOUT, 101 BAD_REQ; valid with done, held until next done
busy  out  1  transaction in progress
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  2  Wishbone address
dat_o  out  8  Wishbone write data
dat_i  in  8  Wishbone read data
ack_i  in  1  Wishbone acknowledge
irq_i  in  1  controller interrupt request

Behaviour:
- Reset values: all outputs 0. After reset, state is INIT.
- INIT: write CSR = 0xC0 (enable + interrupt enable). Next state IDLE.
- Wishbone access:
  - cyc_o, stb_o, we_o, adr_o and dat_o assert together and hold until ack_i is sampled high.
  - All deassert the following cycle; minimum 1 idle cycle between accesses.
  - Reads capture dat_i on the ack cycle.
- CMDR command codes: Write 001, Read_Ack 010, Read_Nak 011, Start 100, Stop 101, Set_Bus 110.
- CMDR response bits: bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.
- Command step = write CMDR, wait for irq_i high, read CMDR (this read clears irq). Decode the response in priority order ERR > AL > NAK > DON.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch the request and set busy.
  - If req_len > MAX_LEN or req_bus >= NUM_I2C_BUSSES: no bus traffic; done with BAD_REQ the next cycle.
- Transaction sequence:
  - SET_BUS: DPR = req_bus, then Set_Bus command step.
  - START: Start command step.
  - ADDR: DPR = {req_addr, req_rw}, then Write command step. NAK here goes to STOP with status NAK.
- Write data loop, req_len iterations:
  - Wait for wr_valid; wr_ready pulses for 1 cycle on the accepting cycle.
  - Write DPR = wr_data, then Write command step.
  - NAK on any byte goes to STOP with status NAK; the remaining bytes are not consumed.
- Read data loop, req_len iterations:
  - Issue Read_Ack for bytes 0..len-2 and Read_Nak for the last byte.
  - After the command step, read DPR.
  - rd_valid pulses 1 cycle with rd_data = the DPR value, on the cycle after the DPR ack.
- req_len = 0: ADDR goes directly to STOP.
- STOP: Stop command step, then done with the latched status (OK unless a NAK was recorded). busy clears; return to IDLE.
- Abort paths:
  - AL in any step: skip Stop (the core has released the bus); done with ARB_LOST.
  - ERR in any step: done with ERR, no Stop.
- Timeout:
  - Counter reloads at each CMDR write and decrements while irq_i is low.
  - On reaching 0: write CSR = 0x00, then CSR = 0xC0 (core reset), then done with TIMEOUT.
- done and req_ready never assert in the same cycle; req_ready rises the cycle after done.
- rst_i mid-transaction: all outputs return to reset values the next cycle, even mid Wishbone access (cyc_o drops without waiting for ack). Restart at INIT.

Test Plan:
- Write req addr 7'h22, bus 0, len 2, wr_data 0x05, 0x06, slave ACKs all -> Wishbone sequence:
  - DPR=0, CMDR=110
  - CMDR=100
  - DPR=0x44, CMDR=001
  - DPR=0x05, CMDR=001
  - DPR=0x06, CMDR=001
  - CMDR=101
  - Then done with status 000; exactly 2 wr_ready pulses.
- Read req addr 7'h22, len 3, slave returns 100, 101, 102 -> DPR=0x45; CMDR 010, 010, 011; rd_valid x3 with data 100, 101, 102; status 000.
- Write len 4, slave NAKs the second data byte -> Stop issued, status 001, exactly 2 wr_ready pulses.
- irq_i held low, IRQ_TIMEOUT=50 after the Start command -> CSR writes 0x00 then 0xC0, status 100, req_ready rises the cycle after done.
- req_len 65 -> no cyc_o activity, done with status 101. req_len 0 write -> Start, address, Stop, status 000.
- rst_i asserted during data byte 1 -> all outputs 0 the next cycle, then CSR=0xC0 written after reset release; a subsequent len-1 write completes with status 000.

Source files
------------

// File: rtl/i2cmb_wb_sequencer.sv
// i2cmb_wb_sequencer: Wishbone master that runs whole byte-level I2C
// transactions on an iicmb_m_wb core (CSR=0, DPR=1, CMDR=2).
module i2cmb_wb_sequencer #(
  parameter int NUM_I2C_BUSSES = 1,
  parameter int MAX_LEN        = 64,
  parameter int IRQ_TIMEOUT    = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [3:0] req_bus,
  input  logic [6:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic [2:0] status,
  output logic       busy,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);

  localparam int TW = $clog2(IRQ_TIMEOUT + 1);

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  localparam logic [2:0] CMD_WRITE    = 3'b001;
  localparam logic [2:0] CMD_READ_ACK = 3'b010;
  localparam logic [2:0] CMD_READ_NAK = 3'b011;
  localparam logic [2:0] CMD_START    = 3'b100;
  localparam logic [2:0] CMD_STOP     = 3'b101;
  localparam logic [2:0] CMD_SET_BUS  = 3'b110;

  localparam logic [2:0] ST_OK      = 3'b000;
  localparam logic [2:0] ST_NAK     = 3'b001;
  localparam logic [2:0] ST_AL      = 3'b010;
  localparam logic [2:0] ST_ERR     = 3'b011;
  localparam logic [2:0] ST_TIMEOUT = 3'b100;
  localparam logic [2:0] ST_BAD     = 3'b101;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WB, S_DPR, S_CMD, S_IRQ, S_DECODE,
    S_WRWAIT, S_RDOUT, S_TO_EN, S_FINISH
  } state_t;

  typedef enum logic [2:0] {P_SETBUS, P_START, P_ADDR, P_DATA, P_STOP} phase_t;

  state_t          state_q, state_d, ret_q, ret_d;
  phase_t          phase_q, phase_d;
  logic            rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;
  logic [3:0]      bus_q, bus_d;
  logic [6:0]      len_q, len_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [7:0]      rdat_q, rdat_d;
  logic [2:0]      stat_q, stat_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [1:0]      adr_q, adr_d;
  logic [7:0]      dat_q, dat_d;
  logic            req_ready_q, req_ready_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            done_q, done_d;
  logic [2:0]      status_q, status_d;
  logic            busy_q, busy_d;
  logic [2:0]      cmd_code;
  logic            last_byte;

  assign cyc_o     = cyc_q;
  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign req_ready = req_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign status    = status_q;
  assign busy      = busy_q;
  assign wr_ready  = (state_q == S_WRWAIT) && wr_valid;
  assign last_byte = (cnt_q == len_q - 7'd1);

  // CMDR opcode for the phase currently being executed
  always_comb begin
    cmd_code = CMD_STOP;
    case (phase_q)
      P_SETBUS: cmd_code = CMD_SET_BUS;
      P_START:  cmd_code = CMD_START;
      P_ADDR:   cmd_code = CMD_WRITE;
      P_DATA:   cmd_code = rw_q ? (last_byte ? CMD_READ_NAK : CMD_READ_ACK) : CMD_WRITE;
      default:  cmd_code = CMD_STOP;
    endcase
  end

  // sequencer: chooses the next Wishbone access and tracks transaction progress
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    bus_d       = bus_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rdat_d      = rdat_q;
    stat_d      = stat_q;
    timer_d     = timer_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    req_ready_d = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    status_d    = status_q;
    busy_d      = busy_q;

    case (state_q)
      S_INIT: begin
        {cyc_d, stb_d, we_d} = 3'b111;
        adr_d   = ADR_CSR;
        dat_d   = 8'hC0;
        ret_d   = S_IDLE;
        state_d = S_WB;
      end
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          rw_d   = req_rw;
          addr_d = req_addr;
          bus_d  = req_bus;
          len_d  = req_len;
          cnt_d  = 7'd0;
          stat_d = ST_OK;
          if ((int'(req_len) > MAX_LEN) || (int'(req_bus) >= NUM_I2C_BUSSES)) begin
            done_d   = 1'b1;
            status_d = ST_BAD;
          end else begin
            busy_d  = 1'b1;
            phase_d = P_SETBUS;
            state_d = S_DPR;
          end
        end
      end
      S_WB: begin
        if (ack_i) begin
          {cyc_d, stb_d, we_d} = 3'b000;
          adr_d   = 2'd0;
          dat_d   = 8'd0;
          rdat_d  = dat_i;
          state_d = ret_q;
          if (ret_q == S_RDOUT) begin
            rd_valid_d = 1'b1;
            rd_data_d  = dat_i;
          end
        end
      end
      S_DPR: begin
        {cyc_d, stb_d, we_d} = 3'b111;
        adr_d   = ADR_DPR;
        dat_d   = (phase_q == P_SETBUS) ? {4'd0, bus_q} : {addr_q, rw_q};
        ret_d   = S_CMD;
        state_d = S_WB;
      end
      S_CMD: begin
        {cyc_d, stb_d, we_d} = 3'b111;
        adr_d   = ADR_CMDR;
        dat_d   = {5'd0, cmd_code};
        timer_d = TW'(IRQ_TIMEOUT);
        ret_d   = S_IRQ;
        state_d = S_WB;
      end
      S_IRQ: begin
        if (irq_i) begin
          {cyc_d, stb_d, we_d} = 3'b110;
          adr_d   = ADR_CMDR;
          dat_d   = 8'd0;
          ret_d   = S_DECODE;
          state_d = S_WB;
        end else if (timer_q == '0) begin
          stat_d  = ST_TIMEOUT;
          {cyc_d, stb_d, we_d} = 3'b111;
          adr_d   = ADR_CSR;
          dat_d   = 8'h00;
          ret_d   = S_TO_EN;
          state_d = S_WB;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_TO_EN: begin
        {cyc_d, stb_d, we_d} = 3'b111;
        adr_d   = ADR_CSR;
        dat_d   = 8'hC0;
        ret_d   = S_FINISH;
        state_d = S_WB;
      end
      S_DECODE: begin
        if (rdat_q[4] || !rdat_q[7] && !rdat_q[6] && !rdat_q[5]) begin
          stat_d  = ST_ERR;
          state_d = S_FINISH;
        end else if (rdat_q[5]) begin
          stat_d  = ST_AL;
          state_d = S_FINISH;
        end else if (rdat_q[6]) begin
          if (phase_q == P_STOP) begin
            state_d = S_FINISH;
          end else begin
            stat_d  = ST_NAK;
            phase_d = P_STOP;
            state_d = S_CMD;
          end
        end else begin
          case (phase_q)
            P_SETBUS: begin
              phase_d = P_START;
              state_d = S_CMD;
            end
            P_START: begin
              phase_d = P_ADDR;
              state_d = S_DPR;
            end
            P_ADDR: begin
              if (len_q == 7'd0) begin
                phase_d = P_STOP;
                state_d = S_CMD;
              end else begin
                phase_d = P_DATA;
                state_d = rw_q ? S_CMD : S_WRWAIT;
              end
            end
            P_DATA: begin
              if (rw_q) begin
                {cyc_d, stb_d, we_d} = 3'b110;
                adr_d   = ADR_DPR;
                dat_d   = 8'd0;
                ret_d   = S_RDOUT;
                state_d = S_WB;
              end else begin
                cnt_d = cnt_q + 7'd1;
                if (last_byte) begin
                  phase_d = P_STOP;
                  state_d = S_CMD;
                end else begin
                  state_d = S_WRWAIT;
                end
              end
            end
            default: state_d = S_FINISH;
          endcase
        end
      end
      S_WRWAIT: begin
        if (wr_valid) begin
          {cyc_d, stb_d, we_d} = 3'b111;
          adr_d   = ADR_DPR;
          dat_d   = wr_data;
          ret_d   = S_CMD;
          state_d = S_WB;
        end
      end
      S_RDOUT: begin
        cnt_d = cnt_q + 7'd1;
        if (last_byte) phase_d = P_STOP;
        state_d = S_CMD;
      end
      S_FINISH: begin
        done_d   = 1'b1;
        status_d = stat_q;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // state register; reset drops every output immediately, even mid-access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      ret_q       <= S_IDLE;
      phase_q     <= P_SETBUS;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      bus_q       <= 4'd0;
      len_q       <= 7'd0;
      cnt_q       <= 7'd0;
      rdat_q      <= 8'd0;
      stat_q      <= ST_OK;
      timer_q     <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 2'd0;
      dat_q       <= 8'd0;
      req_ready_q <= 1'b0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      phase_q     <= phase_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      bus_q       <= bus_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rdat_q      <= rdat_d;
      stat_q      <= stat_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      req_ready_q <= req_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      status_q    <= status_d;
      busy_q      <= busy_d;
    end
  end

endmodule
